// File: rtl/csa_wide_add_sched_pkg.sv
// Shared types and defaults for the chunked carry-select wide adder scheduler.
package csa_wide_add_sched_pkg;

  localparam int DEF_CHUNK_W    = 29;
  localparam int DEF_NUM_CHUNKS = 4;
  localparam int ID_W           = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_chunk_adder.sv
// Combinational W-bit carry-select adder: 4-bit groups plus a narrower remainder group.
module csa_chunk_adder #(
  parameter int W = 29
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG  = W / 4;
  localparam int REM = W % 4;

  logic [NG:0] gc;
  assign gc[0] = cin;

  // Each group precomputes both carry-in cases; the incoming carry only drives a mux.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    assign s1 = s0 + 5'd1;
    assign sum[4*g +: 4] = gc[g] ? s1[3:0] : s0[3:0];
    assign gc[g+1]       = gc[g] ? s1[4]   : s0[4];
  end

  if (REM > 0) begin : g_rem
    logic [REM:0] r0;
    logic [REM:0] r1;
    assign r0 = {1'b0, a[W-1 -: REM]} + {1'b0, b[W-1 -: REM]};
    assign r1 = r0 + {{REM{1'b0}}, 1'b1};
    assign sum[W-1 -: REM] = gc[NG] ? r1[REM-1:0] : r0[REM-1:0];
    assign cout            = gc[NG] ? r1[REM]     : r0[REM];
  end else begin : g_norem
    assign cout = gc[NG];
  end

endmodule

// File: rtl/csa_wide_add_sched.sv
// Two-requester wide adder: round-robin accept, one CHUNK_W pass per cycle, hold result.
// Optional macro CSA_SCHED_OVF_EN adds the registered two's-complement overflow output o_res_ovf.
module csa_wide_add_sched
  import csa_wide_add_sched_pkg::*;
#(
  parameter int  CHUNK_W    = DEF_CHUNK_W,
  parameter int  NUM_CHUNKS = DEF_NUM_CHUNKS,
  localparam int OP_W       = CHUNK_W * NUM_CHUNKS
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req0_valid,
  input  logic            i_req1_valid,
  output logic            o_req0_ready,
  output logic            o_req1_ready,
  input  logic [OP_W-1:0] i_req0_a,
  input  logic [OP_W-1:0] i_req0_b,
  input  logic [OP_W-1:0] i_req1_a,
  input  logic [OP_W-1:0] i_req1_b,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [OP_W-1:0] o_res_sum,
  output logic            o_res_cout,
  output logic [ID_W-1:0] o_res_id,
  output logic [1:0]      o_dbg_state
`ifdef CSA_SCHED_OVF_EN
  , output logic          o_res_ovf
`endif
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, b_q, sum_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              carry_q, cout_q;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   prio_q;  // requester that wins the next contention
  logic [ID_W-1:0]   gnt_id;
  logic              accept, last_chunk;
  logic [CHUNK_W-1:0] ch_a, ch_b, ch_s;
  logic              ch_co;

  // Handshake: a transfer happens on a rising edge where valid && ready. Requesters
  // hold valid and operands until ready; ready is only raised in IDLE, one at a time.
  // The result side holds o_res_valid and its data until a cycle with i_res_ready=1.
  always_comb begin
    gnt_id = '0;
    if (i_req0_valid && i_req1_valid) gnt_id = prio_q;
    else                              gnt_id = i_req1_valid;
  end

  assign accept       = i_rst_n && (state_q == ST_IDLE) && (i_req0_valid || i_req1_valid);
  assign o_req0_ready = accept && (gnt_id == 1'b0);
  assign o_req1_ready = accept && (gnt_id == 1'b1);
  assign last_chunk   = (cnt_q == CNT_W'(NUM_CHUNKS - 1));

  assign ch_a = a_q[int'(cnt_q)*CHUNK_W +: CHUNK_W];
  assign ch_b = b_q[int'(cnt_q)*CHUNK_W +: CHUNK_W];

  csa_chunk_adder #(.W(CHUNK_W)) u_chunk (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry_q),
    .sum  (ch_s),
    .cout (ch_co)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)      state_d = ST_ADD;
      ST_ADD:  if (last_chunk)  state_d = ST_DONE;
      ST_DONE: if (i_res_ready) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

`ifdef CSA_SCHED_OVF_EN
  logic ovf_q;
  // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
  logic ch_ovf;
  assign ch_ovf    = ch_co ^ (ch_a[CHUNK_W-1] ^ ch_b[CHUNK_W-1] ^ ch_s[CHUNK_W-1]);
  assign o_res_ovf = ovf_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= '0;
      prio_q  <= '0;
`ifdef CSA_SCHED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (accept) begin
          a_q     <= (gnt_id == 1'b1) ? i_req1_a : i_req0_a;
          b_q     <= (gnt_id == 1'b1) ? i_req1_b : i_req0_b;
          id_q    <= gnt_id;
          prio_q  <= ~gnt_id;
          carry_q <= 1'b0;
          cnt_q   <= '0;
        end
        ST_ADD: begin
          sum_q[int'(cnt_q)*CHUNK_W +: CHUNK_W] <= ch_s;
          carry_q <= ch_co;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_chunk) begin
            cout_q <= ch_co;
`ifdef CSA_SCHED_OVF_EN
            ovf_q  <= ch_ovf;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_res_valid = (state_q == ST_DONE);
  assign o_res_sum   = sum_q;
  assign o_res_cout  = cout_q;
  assign o_res_id    = id_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_csa_wide_add_sched.sv
// Bench for csa_wide_add_sched: vector table, reset-abort sequence, randomized ops vs arithmetic model.
module tb_csa_wide_add_sched;
  import csa_wide_add_sched_pkg::*;

  localparam int CHUNK_W    = 29;
  localparam int NUM_CHUNKS = 4;
  localparam int OP_W       = CHUNK_W * NUM_CHUNKS;
  localparam int E_W        = OP_W + 3;  // {ovf, id, cout, sum}

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            rdy0, rdy1;
  logic [OP_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [OP_W-1:0] res_sum;
  logic            res_cout;
  logic [0:0]      res_id;
  logic [1:0]      dbg_state;
`ifdef CSA_SCHED_OVF_EN
  logic            res_ovf;
`endif

  csa_wide_add_sched #(.CHUNK_W(CHUNK_W), .NUM_CHUNKS(NUM_CHUNKS)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (req0_valid),
    .i_req1_valid (req1_valid),
    .o_req0_ready (rdy0),
    .o_req1_ready (rdy1),
    .i_req0_a     (req0_a),
    .i_req0_b     (req0_b),
    .i_req1_a     (req1_a),
    .i_req1_b     (req1_b),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_sum    (res_sum),
    .o_res_cout   (res_cout),
    .o_res_id     (res_id),
    .o_dbg_state  (dbg_state)
`ifdef CSA_SCHED_OVF_EN
    , .o_res_ovf  (res_ovf)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int              checks = 0;
  int              failures = 0;
  logic [E_W-1:0]  exp_q[$];
  logic            m_last = 1'b1;  // requester granted most recently; 1 so req0 wins first contention

  task automatic check(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Reference: plain wide unsigned addition; overflow from operand/result signs.
  function automatic logic [E_W-1:0] model(input logic id, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic [OP_W:0] full;
    logic          ovf;
    full = {1'b0, a} + {1'b0, b};
    ovf  = (a[OP_W-1] == b[OP_W-1]) && (full[OP_W-1] != a[OP_W-1]);
    return {ovf, id, full};
  endfunction

  function automatic logic model_pick(input logic v0, input logic v1);
    logic id;
    id = (v0 && v1) ? ~m_last : v1;
    m_last = id;
    return id;
  endfunction

  function automatic logic [OP_W-1:0] rnd_op();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[OP_W-1:0];
  endfunction

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the edge that consumed the result.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [OP_W-1:0] a0, input logic [OP_W-1:0] b0,
                        input logic [OP_W-1:0] a1, input logic [OP_W-1:0] b1,
                        input int hold);
    logic [E_W-1:0] e;
    logic           got;
    int             n;
    e = exp_q.pop_front();
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy0 || rdy1) begin got = 1'b1; break; end
    end
    if (!got) begin
      fail_now("grant_wait");
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    check("grant_onehot", rdy0 ^ rdy1, 1);
    check("grant_id", rdy1, e[E_W-2]);
    @(posedge clk); #1;
    if (e[E_W-2]) req1_valid = 1'b0; else req0_valid = 1'b0;
    n = 1; got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1'b1; break; end
      check("busy_ready", {rdy0, rdy1}, 0);
      @(posedge clk);
      n++;
    end
    if (!got) begin
      fail_now("result_wait");
      return;
    end
    check("latency", n, NUM_CHUNKS + 1);
    check("res_sum", res_sum, e[OP_W-1:0]);
    check("res_cout", res_cout, e[OP_W]);
    check("res_id", res_id, e[E_W-2]);
`ifdef CSA_SCHED_OVF_EN
    check("res_ovf", res_ovf, e[E_W-1]);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_sum", res_sum, e[OP_W-1:0]);
      check("hold_id", res_id, e[E_W-2]);
      check("hold_ready", {rdy0, rdy1}, 0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check("done_ready", {rdy0, rdy1}, 0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("consumed", res_valid, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            v0, v1;
    logic [OP_W-1:0] a0, b0, a1, b1;
    logic            exp_id;
    logic [OP_W-1:0] exp_sum;
    logic            exp_cout;
    int              hold;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [OP_W-1:0] ones;
    logic [OP_W-1:0] half;
    logic            v0, v1, id;
    logic [OP_W-1:0] a0, b0, a1, b1;
    ones = '1;
    half = '0;
    half[OP_W-1] = 1'b1;

    tbl[0] = '{1'b1, 1'b1, 5, 6, 7, 8, 1'b0, 11, 1'b0, 0};
    tbl[1] = '{1'b1, 1'b1, 5, 6, 7, 8, 1'b1, 15, 1'b0, 10};
    tbl[2] = '{1'b1, 1'b1, 5, 6, 7, 8, 1'b0, 11, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b1, 5, 6, 7, 8, 1'b1, 15, 1'b0, 0};
    tbl[4] = '{1'b1, 1'b0, 1, 2, 0, 0, 1'b0, 3, 1'b0, 0};
    tbl[5] = '{1'b1, 1'b0, ones, 1, 0, 0, 1'b0, 0, 1'b1, 2};
    tbl[6] = '{1'b0, 1'b1, 0, 0, ones, ones, 1'b1, ones - 1, 1'b1, 0};

    // reset state
    #3;
    check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0);
    check("rst_cout", res_cout, 0);
    check("rst_id", res_id, 0);
    check("rst_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (tbl[i]) begin
      exp_q.push_back({1'b0, tbl[i].exp_id, tbl[i].exp_cout, tbl[i].exp_sum});
      m_last = tbl[i].exp_id;
      run_op(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1, tbl[i].hold);
    end

    // reset in the middle of chunk 2 aborts the operation
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = ones; req0_b = ones;
    @(negedge clk);
    check("abort_grant", rdy0, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", res_valid, 0);
    check("abort_sum", res_sum, 0);
    check("abort_cout", res_cout, 0);
    check("abort_id", res_id, 0);
    check("abort_ready", {rdy0, rdy1}, 0);
    check("abort_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_no_result", res_valid, 0);
    end
    @(posedge clk); #1;
    exp_q.push_back(model(model_pick(1'b1, 1'b1), 116'd9, ones));
    run_op(1'b1, 1'b1, 116'd9, ones, 116'd3, 116'd4, 1);

    // randomized operations
    for (int k = 0; k < 24; k++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      a0 = rnd_op(); b0 = rnd_op(); a1 = rnd_op(); b1 = rnd_op();
      if ($urandom_range(0, 3) == 0) b0 = ~a0 + OP_W'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) b1 = ~a1;
      id = model_pick(v0, v1);
      exp_q.push_back(id ? model(id, a1, b1) : model(id, a0, b0));
      run_op(v0, v1, a0, b0, a1, b1, $urandom_range(0, 3));
    end

    // signed-overflow corner pair
    req1_valid = 1'b0;
    exp_q.push_back(model(model_pick(1'b1, 1'b0), half, half));
    run_op(1'b1, 1'b0, half, half, 0, 0, 0);
    exp_q.push_back(model(model_pick(1'b1, 1'b0), 116'd1, 116'd1));
    run_op(1'b1, 1'b0, 116'd1, 116'd1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
